// File: rtl/rv32i_header.sv
// Shared definitions for the RV32I execute stage: bus widths and one-hot
// bit positions for ALU operations, major opcodes and exception classes.
// Decode drives these vectors one-hot; the execute stage tests single bits.
package rv32i_header;

    localparam int ALU_WIDTH       = 14;
    localparam int OPCODE_WIDTH    = 11;
    localparam int EXCEPTION_WIDTH = 4;

    // ALU operation bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    // Major opcode bit positions
    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    // Exception bit positions
    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_MRET    = 3;

endpackage

// File: rtl/rv32i_alu.sv
// Purpose: RV32I execute stage - operand select, ALU, branch/jump resolve, rd writeback qualifiers.
// Latency: one cycle; all data outputs are registered into the memory-access stage.
// Backpressure: i_stall holds everything, i_force_stall inserts a bubble, i_flush kills the issued instruction.
module rv32i_alu
    import rv32i_header::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ALU_WIDTH-1:0]       i_alu,
    input  logic [OPCODE_WIDTH-1:0]    i_opcode,
    input  logic [EXCEPTION_WIDTH-1:0] i_exception,
    input  logic [4:0]                 i_rs1_addr,
    input  logic [4:0]                 i_rd_addr,
    input  logic [31:0]                i_rs1,
    input  logic [31:0]                i_rs2,
    input  logic [31:0]                i_imm,
    input  logic [31:0]                i_pc,
    input  logic [2:0]                 i_funct3,
    input  logic                       i_ce,
    input  logic                       i_stall,
    input  logic                       i_force_stall,
    input  logic                       i_flush,
    output logic [4:0]                 o_rs1_addr,
    output logic [4:0]                 o_rd_addr,
    output logic [31:0]                o_rs1,
    output logic [31:0]                o_rs2,
    output logic [31:0]                o_pc,
    output logic [11:0]                o_imm,
    output logic [2:0]                 o_funct3,
    output logic [OPCODE_WIDTH-1:0]    o_opcode,
    output logic [EXCEPTION_WIDTH-1:0] o_exception,
    output logic [31:0]                o_y,
    output logic [31:0]                o_next_pc,
    output logic                       o_change_pc,
    output logic                       o_wr_rd,
    output logic [31:0]                o_rd,
    output logic                       o_rd_valid,
    output logic                       o_stall_from_alu,
    output logic                       o_ce,
    output logic                       o_stall,
    output logic                       o_flush
);

    logic [31:0] op_a, op_b;
    logic [31:0] y_d, next_pc_d, rd_d;
    logic        change_pc_d, wr_rd_d, rd_valid_d, stall_from_alu_d;
    logic        stall_bit, load_en;

    logic [4:0]                 rs1_addr_q, rd_addr_q;
    logic [31:0]                rs1_q, rs2_q, pc_q, y_q, next_pc_q, rd_q;
    logic [11:0]                imm_q;
    logic [2:0]                 funct3_q;
    logic [OPCODE_WIDTH-1:0]    opcode_q;
    logic [EXCEPTION_WIDTH-1:0] exception_q;
    logic                       change_pc_q, wr_rd_q, rd_valid_q, stall_from_alu_q, ce_q;

    // A flush overrides any stall request so the killed slot can drain.
    assign o_stall   = (i_stall | i_force_stall) & ~i_flush;
    assign o_flush   = i_flush;
    assign stall_bit = o_stall | i_stall;
    assign load_en   = i_ce & ~stall_bit;

    // Operand select and ALU; compare ops yield 0/1 in bit 0, no op bit gives zero.
    always_comb begin
        op_a = (i_opcode[OP_JAL] | i_opcode[OP_AUIPC]) ? i_pc : i_rs1;
        op_b = (i_opcode[OP_RTYPE] | i_opcode[OP_BRANCH]) ? i_rs2 : i_imm;
        y_d  = '0;
        if (i_alu[ALU_ADD])       y_d = op_a + op_b;
        else if (i_alu[ALU_SUB])  y_d = op_a - op_b;
        else if (i_alu[ALU_SLT])  y_d = {31'd0, $signed(op_a) < $signed(op_b)};
        else if (i_alu[ALU_SLTU]) y_d = {31'd0, op_a < op_b};
        else if (i_alu[ALU_XOR])  y_d = op_a ^ op_b;
        else if (i_alu[ALU_OR])   y_d = op_a | op_b;
        else if (i_alu[ALU_AND])  y_d = op_a & op_b;
        else if (i_alu[ALU_SLL])  y_d = op_a << op_b[4:0];
        else if (i_alu[ALU_SRL])  y_d = op_a >> op_b[4:0];
        else if (i_alu[ALU_SRA])  y_d = $unsigned($signed(op_a) >>> op_b[4:0]);
        else if (i_alu[ALU_EQ])   y_d = {31'd0, op_a == op_b};
        else if (i_alu[ALU_NEQ])  y_d = {31'd0, op_a != op_b};
        else if (i_alu[ALU_GE])   y_d = {31'd0, $signed(op_a) >= $signed(op_b)};
        else if (i_alu[ALU_GEU])  y_d = {31'd0, op_a >= op_b};
    end

    // Redirect target, rd value and writeback qualifiers.
    always_comb begin
        next_pc_d = i_opcode[OP_JALR] ? ((i_rs1 + i_imm) & ~32'd1) : (i_pc + i_imm);
        change_pc_d = i_ce & ((i_opcode[OP_BRANCH] & y_d[0]) | i_opcode[OP_JAL] | i_opcode[OP_JALR]);
        if (i_opcode[OP_JAL] | i_opcode[OP_JALR]) rd_d = i_pc + 32'd4;
        else if (i_opcode[OP_LUI])               rd_d = i_imm;
        else                                     rd_d = y_d;
        wr_rd_d = ~(i_opcode[OP_BRANCH] | i_opcode[OP_STORE] | i_opcode[OP_FENCE]
                    | (i_opcode[OP_SYSTEM] & (i_funct3 == 3'd0)));
        rd_valid_d = i_opcode[OP_RTYPE] | i_opcode[OP_ITYPE] | i_opcode[OP_JAL]
                   | i_opcode[OP_JALR] | i_opcode[OP_LUI] | i_opcode[OP_AUIPC];
        stall_from_alu_d = i_opcode[OP_LOAD] | i_opcode[OP_STORE];
    end

    // Pipeline register into the memory-access stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rs1_addr_q       <= '0;
            rd_addr_q        <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            funct3_q         <= '0;
            opcode_q         <= '0;
            exception_q      <= '0;
            y_q              <= '0;
            next_pc_q        <= '0;
            rd_q             <= '0;
            change_pc_q      <= 1'b0;
            wr_rd_q          <= 1'b0;
            rd_valid_q       <= 1'b0;
            stall_from_alu_q <= 1'b0;
            ce_q             <= 1'b0;
        end else begin
            if (load_en) begin
                rs1_addr_q       <= i_rs1_addr;
                rd_addr_q        <= i_rd_addr;
                rs1_q            <= i_rs1;
                rs2_q            <= i_rs2;
                pc_q             <= i_pc;
                imm_q            <= i_imm[11:0];
                funct3_q         <= i_funct3;
                opcode_q         <= i_opcode;
                exception_q      <= i_exception;
                y_q              <= y_d;
                next_pc_q        <= next_pc_d;
                rd_q             <= rd_d;
                wr_rd_q          <= wr_rd_d;
                rd_valid_q       <= rd_valid_d;
                stall_from_alu_q <= stall_from_alu_d;
            end
            // Redirect is a one-cycle strobe and never survives a flush.
            change_pc_q <= load_en & ~i_flush & change_pc_d;
            // Valid: follows i_ce when moving, bubbles on force-stall, holds on i_stall.
            if (!stall_bit)    ce_q <= i_ce & ~i_flush;
            else if (!i_stall) ce_q <= 1'b0;
        end
    end

    assign o_rs1_addr       = rs1_addr_q;
    assign o_rd_addr        = rd_addr_q;
    assign o_rs1            = rs1_q;
    assign o_rs2            = rs2_q;
    assign o_pc             = pc_q;
    assign o_imm            = imm_q;
    assign o_funct3         = funct3_q;
    assign o_opcode         = opcode_q;
    assign o_exception      = exception_q;
    assign o_y              = y_q;
    assign o_next_pc        = next_pc_q;
    assign o_change_pc      = change_pc_q;
    assign o_wr_rd          = wr_rd_q;
    assign o_rd             = rd_q;
    assign o_rd_valid       = rd_valid_q;
    assign o_stall_from_alu = stall_from_alu_q;
    assign o_ce             = ce_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for the RV32I execute stage.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_rv32i_alu;
    import rv32i_header::*;

    logic                       i_clk = 1'b0;
    logic                       i_rst_n;
    logic [ALU_WIDTH-1:0]       i_alu;
    logic [OPCODE_WIDTH-1:0]    i_opcode;
    logic [EXCEPTION_WIDTH-1:0] i_exception;
    logic [4:0]                 i_rs1_addr, i_rd_addr;
    logic [31:0]                i_rs1, i_rs2, i_imm, i_pc;
    logic [2:0]                 i_funct3;
    logic                       i_ce, i_stall, i_force_stall, i_flush;
    logic [4:0]                 o_rs1_addr, o_rd_addr;
    logic [31:0]                o_rs1, o_rs2, o_pc, o_y, o_next_pc, o_rd;
    logic [11:0]                o_imm;
    logic [2:0]                 o_funct3;
    logic [OPCODE_WIDTH-1:0]    o_opcode;
    logic [EXCEPTION_WIDTH-1:0] o_exception;
    logic                       o_change_pc, o_wr_rd, o_rd_valid, o_stall_from_alu;
    logic                       o_ce, o_stall, o_flush;

    int checks = 0;
    int errors = 0;

    rv32i_alu dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_alu(i_alu), .i_opcode(i_opcode),
        .i_exception(i_exception), .i_rs1_addr(i_rs1_addr), .i_rd_addr(i_rd_addr),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc), .i_funct3(i_funct3),
        .i_ce(i_ce), .i_stall(i_stall), .i_force_stall(i_force_stall), .i_flush(i_flush),
        .o_rs1_addr(o_rs1_addr), .o_rd_addr(o_rd_addr), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_pc(o_pc), .o_imm(o_imm), .o_funct3(o_funct3), .o_opcode(o_opcode),
        .o_exception(o_exception), .o_y(o_y), .o_next_pc(o_next_pc),
        .o_change_pc(o_change_pc), .o_wr_rd(o_wr_rd), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
        .o_stall_from_alu(o_stall_from_alu), .o_ce(o_ce), .o_stall(o_stall), .o_flush(o_flush)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction with i_ce=1 and no pipeline controls.
    task automatic drive(input int alu, input int opc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [2:0] f3);
        i_alu         = '0;
        i_opcode      = '0;
        if (alu >= 0) i_alu[alu] = 1'b1;
        i_opcode[opc] = 1'b1;
        i_rs1         = rs1;
        i_rs2         = rs2;
        i_imm         = imm;
        i_pc          = pc;
        i_funct3      = f3;
        i_ce          = 1'b1;
        i_stall       = 1'b0;
        i_force_stall = 1'b0;
        i_flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_exception = '0;
        i_rs1_addr = '0;
        i_rd_addr = '0;
        drive(ALU_ADD, OP_RTYPE, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        i_ce = 1'b0;
        #3;
        check("rst_ce", {31'd0, o_ce}, 32'd0);
        check("rst_y", o_y, 32'd0);
        check("rst_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        // ADD RTYPE 5+7, with address/exception pass-through
        drive(ALU_ADD, OP_RTYPE, 32'd5, 32'd7, 32'h0000_0ABC, 32'd0, 3'd0);
        i_rs1_addr = 5'd3;
        i_rd_addr = 5'd9;
        i_exception = 4'b0010;
        step();
        check("add_y", o_y, 32'd12);
        check("add_rd", o_rd, 32'd12);
        check("add_wr_rd", {31'd0, o_wr_rd}, 32'd1);
        check("add_rd_valid", {31'd0, o_rd_valid}, 32'd1);
        check("add_ce", {31'd0, o_ce}, 32'd1);
        check("add_change_pc", {31'd0, o_change_pc}, 32'd0);
        check("add_rd_addr", {27'd0, o_rd_addr}, 32'd9);
        check("add_exception", {28'd0, o_exception}, 32'd2);
        check("add_imm", {20'd0, o_imm}, 32'h0000_0ABC);
        i_exception = '0;

        drive(ALU_SUB, OP_RTYPE, 32'd3, 32'd5, 32'd0, 32'd0, 3'd0);
        step();
        check("sub_y", o_y, 32'hFFFF_FFFE);

        drive(ALU_SRA, OP_ITYPE, 32'h8000_0000, 32'd99, 32'd4, 32'd0, 3'd5);
        step();
        check("sra_y", o_y, 32'hF800_0000);

        drive(ALU_SRL, OP_ITYPE, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 3'd5);
        step();
        check("srl_y", o_y, 32'h0800_0000);

        drive(ALU_SLT, OP_RTYPE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3'd2);
        step();
        check("slt_y", o_y, 32'd1);

        drive(ALU_SLTU, OP_RTYPE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 3'd3);
        step();
        check("sltu_y", o_y, 32'd0);

        drive(-1, OP_RTYPE, 32'd5, 32'd7, 32'd0, 32'd0, 3'd0);
        step();
        check("noop_y", o_y, 32'd0);

        // Taken branch, then an idle cycle: strobe must drop, data holds
        drive(ALU_EQ, OP_BRANCH, 32'd3, 32'd3, 32'h20, 32'h100, 3'd0);
        step();
        check("beq_change_pc", {31'd0, o_change_pc}, 32'd1);
        check("beq_next_pc", o_next_pc, 32'h120);
        check("beq_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        i_ce = 1'b0;
        step();
        check("idle_change_pc", {31'd0, o_change_pc}, 32'd0);
        check("idle_ce", {31'd0, o_ce}, 32'd0);
        check("idle_next_pc_hold", o_next_pc, 32'h120);

        drive(ALU_EQ, OP_BRANCH, 32'd3, 32'd4, 32'h20, 32'h100, 3'd0);
        step();
        check("bne_change_pc", {31'd0, o_change_pc}, 32'd0);

        drive(ALU_ADD, OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h40, 3'd0);
        step();
        check("jalr_next_pc", o_next_pc, 32'h1002);
        check("jalr_rd", o_rd, 32'h44);
        check("jalr_change_pc", {31'd0, o_change_pc}, 32'd1);

        drive(ALU_ADD, OP_JAL, 32'hDEAD, 32'd0, 32'h10, 32'h200, 3'd0);
        step();
        check("jal_next_pc", o_next_pc, 32'h210);
        check("jal_rd", o_rd, 32'h204);

        drive(ALU_ADD, OP_AUIPC, 32'hDEAD, 32'd0, 32'h3000, 32'h200, 3'd0);
        step();
        check("auipc_rd", o_rd, 32'h3200);

        drive(ALU_ADD, OP_LUI, 32'hDEAD, 32'd0, 32'h1234_5000, 32'd0, 3'd0);
        step();
        check("lui_rd", o_rd, 32'h1234_5000);

        drive(ALU_ADD, OP_SYSTEM, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        step();
        check("ecall_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        drive(ALU_ADD, OP_SYSTEM, 32'd0, 32'd0, 32'd0, 32'd0, 3'd1);
        step();
        check("csr_wr_rd", {31'd0, o_wr_rd}, 32'd1);
        check("csr_rd_valid", {31'd0, o_rd_valid}, 32'd0);

        // LOAD, then two cycles of i_stall with a different instruction waiting
        drive(ALU_ADD, OP_LOAD, 32'h1000, 32'd0, 32'd8, 32'd0, 3'd2);
        step();
        check("load_stall_from_alu", {31'd0, o_stall_from_alu}, 32'd1);
        check("load_rd_valid", {31'd0, o_rd_valid}, 32'd0);
        check("load_y", o_y, 32'h1008);
        drive(ALU_ADD, OP_RTYPE, 32'd1, 32'd1, 32'd0, 32'd0, 3'd0);
        i_stall = 1'b1;
        #1;
        check("stall_o_stall", {31'd0, o_stall}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_y_hold", o_y, 32'h1008);
            check("stall_ce_hold", {31'd0, o_ce}, 32'd1);
        end
        i_stall = 1'b0;
        step();
        check("resume_y", o_y, 32'd2);
        check("resume_stall_from_alu", {31'd0, o_stall_from_alu}, 32'd0);

        // Force-stall inserts a bubble and holds data
        drive(ALU_ADD, OP_RTYPE, 32'd10, 32'd10, 32'd0, 32'd0, 3'd0);
        i_force_stall = 1'b1;
        #1;
        check("fstall_o_stall", {31'd0, o_stall}, 32'd1);
        step();
        check("fstall_ce_bubble", {31'd0, o_ce}, 32'd0);
        check("fstall_y_hold", o_y, 32'd2);

        // Flush overrides force-stall and kills a JAL redirect
        drive(ALU_ADD, OP_JAL, 32'd0, 32'd0, 32'h10, 32'h300, 3'd0);
        i_force_stall = 1'b1;
        i_flush = 1'b1;
        #1;
        check("flush_o_flush", {31'd0, o_flush}, 32'd1);
        check("flush_o_stall", {31'd0, o_stall}, 32'd0);
        step();
        check("flush_ce", {31'd0, o_ce}, 32'd0);
        check("flush_change_pc", {31'd0, o_change_pc}, 32'd0);

        // Asynchronous reset mid-run
        drive(ALU_ADD, OP_JAL, 32'd0, 32'd0, 32'h10, 32'h300, 3'd0);
        step();
        check("pre_rst_ce", {31'd0, o_ce}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_ce", {31'd0, o_ce}, 32'd0);
        check("arst_change_pc", {31'd0, o_change_pc}, 32'd0);
        check("arst_rd", o_rd, 32'd0);
        check("arst_next_pc", o_next_pc, 32'd0);
        check("arst_wr_rd", {31'd0, o_wr_rd}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
